pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised, pipelined ripple-carry adder/subtractor. It is the streaming successor to the team's single-bit combinational full adder. Operands are split into STAGES equal slices, one registered slice adder per stage, with a valid/ready handshake and whole-pipeline backpressure. It sits in datapaths needing wide add/sub at high clock rate, with a carry-in, carry-out and signed-overflow flag per result.

Parameters:
WIDTH, 8, operand/result width in bits; must be divisible by STAGES.
STAGES, 2, number of pipeline stages; 1 <= STAGES <= WIDTH; slice width SW = WIDTH/STAGES.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  pipeline can accept a beat this cycle
a  input  WIDTH  operand A (unsigned/two's complement)
b  input  WIDTH  operand B
cin  input  1  carry-in (ADD) / borrow-in (SUB)
mode  input  1  0 = ADD, 1 = SUB
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  ADD: carry-out; SUB: 1 = no borrow, 0 = borrow
ovf  output  1  signed overflow of the result

Behaviour:
- Reset (rst_n low, async): all stage valid bits, sum, cout and ovf clear to 0. out_valid = 0. in_ready = 1 once rst_n is high. Reset mid-operation discards all in-flight beats, with no partial output.
- Operand transform at input: ADD uses beff = b, ceff = cin. SUB uses beff = ~b, ceff = ~cin, so the result is a - b - cin.
- Stage k (0..STAGES-1) adds slice k of a and beff plus the carry registered by stage k-1 (stage 0 uses ceff). It registers the SW-bit partial sum and the carry.
- Higher slices of a/beff travel through skew registers. Lower result slices travel through deskew registers. All slices of one beat emerge together.
- Latency: exactly STAGES cycles from the accept edge (in_valid && in_ready) to out_valid, with no bubbles. Throughput is 1 beat/cycle.
- Stall: stall = out_valid && !out_ready, and in_ready = !stall.
  - While stalled, every pipeline register (data and valid) holds.
  - sum/cout/ovf stay stable while out_valid && !out_ready.
- When not stalled, bubbles (in_valid = 0) propagate as valid = 0. They do not compress; no register holds during a bubble.
- cout is the final stage carry.
- ovf = (a[MSB] == beff[MSB]) && (sum[MSB] != a[MSB]), using operand MSBs carried alongside the beat.
- mode and cin are sampled with the beat. Mixed ADD/SUB streams are legal back-to-back.
- STAGES = 1 degenerates to a single registered WIDTH-bit adder with 1-cycle latency.
- Accept and drain in the same cycle while out_ready = 1 is legal and keeps full throughput.

Decomposition:
- Shared header adder_defs.vh holds MODE_ADD = 1'b0 and MODE_SUB = 1'b1. It is also used by other arithmetic blocks.
- One sub-module, adder_slice (parameter SW), is instantiated STAGES times via generate. It contains:
  - a combinational SW-bit ripple add with carry-in;
  - registered sum and carry, with a hold-enable input.
- Skew and deskew registers plus valid/stall logic live in pipelined_adder.

Test Plan:
- WIDTH=8, STAGES=2, ADD, a=0xFF, b=0x01, cin=0 -> 2 cycles later sum=0x00, cout=1, ovf=0.
- ADD a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then SUB a=0x05, b=0x07, cin=0 on the next cycle -> sum=0xFE, cout=0 (borrow), ovf=0, one cycle after the first result.
- Stream 4 beats back-to-back with out_ready=1, then drop out_ready for 3 cycles mid-stream -> in_ready low for those cycles. The held sum is unchanged. All 4 results arrive in order, with none lost or duplicated.
- Assert rst_n low for 1 cycle while 2 beats are in flight -> out_valid=0 immediately. No stale results appear after reset release, and the next accepted beat emerges after STAGES cycles.
- WIDTH=4 with STAGES=1, 2 and 4: exhaustive a, b, cin and mode (1024 vectors) with random out_ready. sum/cout/ovf must match the reference model {cout,sum} = a + beff + ceff.
- Bubble pattern in_valid = 1,0,1,0 with out_ready=1 -> out_valid = 1,0,1,0 delayed by exactly STAGES cycles.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encodings
// and the signed-overflow rule applied to the final result.
package pipelined_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Overflow when both effective operands share a sign that the result lacks.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// One SW-bit slice of the pipelined adder: ripple-carry add with carry-in,
// followed by a holdable register for the partial sum and carry-out.
module adder_slice #(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_hold,
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    input  logic          i_cin,
    output logic [SW-1:0] o_sum,
    output logic          o_cout
);

    logic [SW-1:0] w_sum;
    logic [SW:0]   w_c;

    always_comb begin
        w_sum  = '0;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < SW; i++) begin
            w_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sum  <= '0;
            o_cout <= 1'b0;
        end else if (!i_hold) begin
            o_sum  <= w_sum;
            o_cout <= w_c[SW];
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Streaming WIDTH-bit adder/subtractor split into STAGES registered slices,
// with operand skew, result deskew and whole-pipeline backpressure.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    logic             w_stall;
    logic [WIDTH-1:0] w_beff;
    logic             w_ceff;
    logic [STAGES-1:0] r_vld;
    logic             r_a_msb;
    logic             r_b_msb;

    // Subtraction is a + ~b + ~cin, giving a - b - cin.
    assign w_beff    = (mode == MODE_SUB) ? ~b   : b;
    assign w_ceff    = (mode == MODE_SUB) ? ~cin : cin;

    assign out_valid = r_vld[STAGES-1];
    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = !w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (!w_stall) begin
            r_vld <= (r_vld << 1) | STAGES'(in_valid);
        end
    end

    // Stage k sees the not-yet-added operand slices aligned so its slice sits
    // at bit 0, and w_res holds all result slices produced so far for its beat.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int RW = (STAGES - k) * SW;

        logic [RW-1:0]         w_a;
        logic [RW-1:0]         w_b;
        logic                  w_cin;
        logic [SW-1:0]         w_sum;
        logic                  w_cout;
        logic [(k+1)*SW-1:0]   w_res;

        if (k == 0) begin : g_in
            assign w_a   = a;
            assign w_b   = w_beff;
            assign w_cin = w_ceff;
            assign w_res = w_sum;
        end else begin : g_skew
            logic [RW-1:0]   r_a;
            logic [RW-1:0]   r_b;
            logic [k*SW-1:0] r_lo;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a  <= '0;
                    r_b  <= '0;
                    r_lo <= '0;
                end else if (!w_stall) begin
                    r_a  <= g_stg[k-1].w_a[RW+SW-1:SW];
                    r_b  <= g_stg[k-1].w_b[RW+SW-1:SW];
                    r_lo <= g_stg[k-1].w_res;
                end
            end

            assign w_a   = r_a;
            assign w_b   = r_b;
            assign w_cin = g_stg[k-1].w_cout;
            assign w_res = {w_sum, r_lo};
        end

        adder_slice #(.SW(SW)) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_hold (w_stall),
            .i_a    (w_a[SW-1:0]),
            .i_b    (w_b[SW-1:0]),
            .i_cin  (w_cin),
            .o_sum  (w_sum),
            .o_cout (w_cout)
        );
    end

    // Operand sign bits ride alongside the final slice for the overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (!w_stall) begin
            r_a_msb <= g_stg[STAGES-1].w_a[SW-1];
            r_b_msb <= g_stg[STAGES-1].w_b[SW-1];
        end
    end

    assign sum  = g_stg[STAGES-1].w_res;
    assign cout = g_stg[STAGES-1].w_cout;
    assign ovf  = ovf_flag(r_a_msb, r_b_msb, sum[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: an 8-bit/2-stage instance for directed, stall, reset and
// random traffic, plus 4-bit instances with 1, 2 and 4 stages run exhaustively.
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    localparam int S8 = 2;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        longint     t;
        bit         lat;
    } e8_t;

    typedef struct {
        logic [3:0] s;
        logic       c;
        logic       o;
    } e4_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, cin, mode, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    logic       iv4 [3];
    logic       ir4 [3];
    logic       ov4 [3];
    logic       or4 [3];
    logic       c4i [3];
    logic       m4  [3];
    logic       co4 [3];
    logic       of4 [3];
    logic [3:0] a4  [3];
    logic [3:0] b4  [3];
    logic [3:0] s4  [3];

    e8_t q8 [$];
    e4_t q4 [3][$];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  rnd8 = 0;
    bit  rnd4 = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(S8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void ref_model(input int w, input int av, input int bv, input int ci,
                                      input int md, output int s, output int c, output int o);
        int mask, half, sa, sb, tot, st;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        sa   = (av >= half) ? av - (1 << w) : av;
        sb   = (bv >= half) ? bv - (1 << w) : bv;
        if (md == 0) begin
            tot = av + bv + ci;
            c   = (tot > mask) ? 1 : 0;
            st  = sa + sb + ci;
        end else begin
            tot = av - bv - ci;
            c   = (av >= bv + ci) ? 1 : 0;
            st  = sa - sb - ci;
        end
        s = tot & mask;
        o = (st >= half || st < -half) ? 1 : 0;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_w4
        localparam int S4 = (i == 0) ? 1 : (i == 1) ? 2 : 4;
        e4_t e;

        pipelined_adder #(.WIDTH(4), .STAGES(S4)) u_dut4 (
            .clk(clk), .rst_n(rst_n), .in_valid(iv4[i]), .in_ready(ir4[i]),
            .a(a4[i]), .b(b4[i]), .cin(c4i[i]), .mode(m4[i]), .out_valid(ov4[i]),
            .out_ready(or4[i]), .sum(s4[i]), .cout(co4[i]), .ovf(of4[i])
        );

        always @(negedge clk) begin
            if (rst_n && ov4[i] && or4[i]) begin
                if (q4[i].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL w4_unexpected[S=%0d]: got sum %0h, expected no beat", S4, s4[i]);
                end else begin
                    e = q4[i].pop_front();
                    chk($sformatf("w4_sum[S=%0d]", S4), s4[i], e.s);
                    chk($sformatf("w4_cout[S=%0d]", S4), co4[i], e.c);
                    chk($sformatf("w4_ovf[S=%0d]", S4), of4[i], e.o);
                end
            end
        end
    end

    e8_t        e8;
    logic [9:0] held;
    bit         hold_pend = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {sum, cout, ovf}, held);
            end
            hold_pend = out_valid && !out_ready;
            held      = {sum, cout, ovf};
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got sum %0h, expected no beat", sum);
                end else begin
                    e8 = q8.pop_front();
                    chk("sum", sum, e8.s);
                    chk("cout", cout, e8.c);
                    chk("ovf", ovf, e8.o);
                    if (e8.lat) chk("latency", ($time - 5 - e8.t) / 10 + 1, S8);
                end
            end
        end
    end

    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic md, input bit lat);
        e8_t e;
        int  s, c, o;
        a = av; b = bv; cin = ci; mode = md; in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ref_model(8, int'(av), int'(bv), int'(ci), int'(md), s, c, o);
                e.s = 8'(s); e.c = 1'(c); e.o = 1'(o); e.t = longint'($time) + 5; e.lat = lat;
                q8.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send8_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drive4(input int i);
        e4_t e;
        int  s, c, o, av, bv, ci, md;
        bit  ok;
        for (int v = 0; v < 1024; v++) begin
            if ($urandom % 4 == 0) begin
                @(posedge clk); #1;
            end
            bv = v & 15; av = (v >> 4) & 15; ci = (v >> 8) & 1; md = (v >> 9) & 1;
            a4[i] = 4'(av); b4[i] = 4'(bv); c4i[i] = 1'(ci); m4[i] = 1'(md); iv4[i] = 1'b1;
            ok = 0;
            for (int n = 0; n < 200 && !ok; n++) begin
                @(negedge clk);
                if (ir4[i]) begin
                    ref_model(4, av, bv, ci, md, s, c, o);
                    e.s = 4'(s); e.c = 1'(c); e.o = 1'(o);
                    q4[i].push_back(e);
                    ok = 1;
                end
                @(posedge clk); #1;
            end
            iv4[i] = 1'b0;
            if (!ok) begin
                chk($sformatf("drive4_timeout[%0d]", i), 0, 1);
                return;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd8) out_ready = ($urandom % 4) != 0;
            if (rnd4) for (int i = 0; i < 3; i++) or4[i] = ($urandom % 3) != 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    bit [7:0] ovs;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; mode = MODE_ADD; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv4[i] = 1'b0; a4[i] = '0; b4[i] = '0; c4i[i] = 1'b0; m4[i] = 1'b0; or4[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        for (int i = 0; i < 3; i++) chk("rst_w4_valid", ov4[i], 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed carry, overflow and borrow cases, back to back.
        send8(8'hFF, 8'h01, 1'b0, MODE_ADD, 1);
        send8(8'h7F, 8'h01, 1'b0, MODE_ADD, 1);
        send8(8'h05, 8'h07, 1'b0, MODE_SUB, 1);
        send8(8'h80, 8'h01, 1'b1, MODE_SUB, 1);
        repeat (5) @(posedge clk); #1;

        // Mid-stream backpressure for three cycles.
        fork
            begin
                for (int n = 0; n < 4; n++) send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("in_ready_stall", in_ready, 0);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk); #1;

        // Reset with beats in flight: they must vanish.
        for (int n = 0; n < 3; n++) send8(8'($urandom), 8'($urandom), 1'b0, MODE_ADD, 0);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        q8.delete();
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        send8(8'h3C, 8'h0F, 1'b1, MODE_ADD, 1);
        repeat (4) @(posedge clk); #1;

        // Bubble pattern 1,0,1,0.
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    ovs[k] = out_valid;
                    @(posedge clk);
                end
            end
            begin
                send8(8'h12, 8'h34, 1'b0, MODE_ADD, 1);
                @(posedge clk); #1;
                send8(8'h56, 8'h78, 1'b1, MODE_SUB, 1);
            end
        join
        for (int k = 0; k < 8; k++) chk($sformatf("bubble_valid[%0d]", k), ovs[k], (k == S8 || k == S8 + 2));
        #1;

        // Random mixed traffic with random backpressure.
        rnd8 = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom % 3 == 0) begin
                @(posedge clk); #1;
            end
            send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        rnd8 = 0;
        out_ready = 1'b1;

        // Exhaustive 4-bit vectors on all three stage counts.
        rnd4 = 1;
        fork
            drive4(0);
            drive4(1);
            drive4(2);
        join
        rnd4 = 0;
        for (int i = 0; i < 3; i++) or4[i] = 1'b1;

        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (q8.size() == 0 && q4[0].size() == 0 && q4[1].size() == 0 && q4[2].size() == 0) break;
        end
        chk("drain_q8", q8.size(), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("drain_q4[%0d]", i), q4[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
